// File: rtl/pim_psum_accum_if.sv
// Stream interface for the partial-sum accumulator: partial sums in, requantized results out.
// Both directions use valid/ready. A transfer happens on a rising edge where valid and ready are both high.
// The sender holds data stable while valid is high and ready is low, and data is ignored while valid is low.
interface pim_psum_accum_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [IN_W-1:0]  in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pim_psum_accum.sv
// Accumulates TILES signed partial sums per output neuron, then requantizes them
// (round, arithmetic shift, optional ReLU, clip) into a 2-entry result FIFO.
module pim_psum_accum #(
  parameter int IN_W  = 16,
  parameter int ACC_W = 24,
  parameter int OUT_W = 8,
  parameter int TILES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [4:0]       shift,
  input  logic             relu_en,
  output logic             sat_flag,
  pim_psum_accum_if.slave  bus
);
  localparam int TC_W = (TILES > 1) ? $clog2(TILES) : 1;
  localparam logic [TC_W-1:0] TC_LAST = TC_W'(TILES - 1);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;
  localparam logic [4:0] SH_MAX = 5'(ACC_W - 1);

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [TC_W-1:0]         tile_q, tile_d;
  logic                    sat_q, sat_d;
  logic signed [OUT_W-1:0] fifo_q [2];
  logic                    wr_ptr_q, rd_ptr_q;
  logic [1:0]              count_q, count_d;
  logic                    in_ready_q;

  logic                    accept, last, push, pop;
  logic [ACC_W:0]          sum_w, rnd_bias, rnd_w;
  logic                    acc_ovf, rnd_ovf, clip_ovf;
  logic signed [ACC_W-1:0] sum_sat, rnd_sat, shifted, relu_val;
  logic [4:0]              sh;
  logic signed [OUT_W-1:0] result;

  always_comb begin
    accept = bus.in_valid & in_ready_q;
    last   = (tile_q == TC_LAST);

    // One guard bit above the accumulator detects signed overflow on the add.
    sum_w   = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-IN_W){bus.in_data[IN_W-1]}}, bus.in_data};
    acc_ovf = sum_w[ACC_W] ^ sum_w[ACC_W-1];
    sum_sat = acc_ovf ? (sum_w[ACC_W] ? ACC_MIN : ACC_MAX) : sum_w[ACC_W-1:0];

    sh       = (shift > SH_MAX) ? SH_MAX : shift;
    rnd_bias = '0;
    if (sh != 5'd0) rnd_bias = (ACC_W+1)'(1) << (sh - 5'd1);
    rnd_w    = {sum_sat[ACC_W-1], sum_sat} + rnd_bias;
    rnd_ovf  = rnd_w[ACC_W] ^ rnd_w[ACC_W-1];
    rnd_sat  = rnd_ovf ? (rnd_w[ACC_W] ? ACC_MIN : ACC_MAX) : rnd_w[ACC_W-1:0];
    shifted  = rnd_sat >>> sh;

    relu_val = shifted;
    if (relu_en && shifted[ACC_W-1]) relu_val = '0;

    clip_ovf = 1'b0;
    result   = relu_val[OUT_W-1:0];
    if (relu_val > OUT_MAX) begin
      result   = OUT_MAX[OUT_W-1:0];
      clip_ovf = 1'b1;
    end else if (relu_val < OUT_MIN) begin
      result   = OUT_MIN[OUT_W-1:0];
      clip_ovf = 1'b1;
    end

    push    = accept & last;
    pop     = (count_q != 2'd0) & bus.out_ready;
    count_d = count_q + {1'b0, push} - {1'b0, pop};

    acc_d  = acc_q;
    tile_d = tile_q;
    sat_d  = sat_q;
    if (accept) begin
      if (last) begin
        acc_d  = '0;
        tile_d = '0;
      end else begin
        acc_d  = sum_sat;
        tile_d = tile_q + TC_W'(1);
      end
      sat_d = sat_q | acc_ovf | (last & (rnd_ovf | clip_ovf));
    end
  end

  // Clear overrides accept and pop; the FIFO never overflows since in_ready is low when full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      tile_q     <= '0;
      sat_q      <= 1'b0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      in_ready_q <= 1'b1;
    end else if (clr) begin
      acc_q      <= '0;
      tile_q     <= '0;
      sat_q      <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      in_ready_q <= 1'b1;
    end else begin
      acc_q   <= acc_d;
      tile_q  <= tile_d;
      sat_q   <= sat_d;
      count_q <= count_d;
      in_ready_q <= (count_d != 2'd2);
      if (push) begin
        fifo_q[wr_ptr_q] <= result;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (count_q != 2'd0);
  assign bus.out_data  = (count_q != 2'd0) ? fifo_q[rd_ptr_q] : '0;
  assign sat_flag      = sat_q;
endmodule

// File: tb/tb_pim_psum_accum.sv
// Directed bench for pim_psum_accum: hand-computed groups of partials, FIFO back-pressure,
// reset and clear behaviour, with an output scoreboard driven by an expected queue.
module tb_pim_psum_accum;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic [4:0] shift = 5'd0;
  logic       relu_en = 1'b0;
  logic       sat_flag;

  int checks = 0;
  int errors = 0;
  int stalls = 0;
  logic [7:0] exp_q[$];

  pim_psum_accum_if #(.IN_W(16), .OUT_W(8)) bus ();

  pim_psum_accum #(.IN_W(16), .ACC_W(24), .OUT_W(8), .TILES(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .shift    (shift),
    .relu_en  (relu_en),
    .sat_flag (sat_flag),
    .bus      (bus)
  );

  // clock/reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // drivers: all driving happens 1 time unit after a rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_partial(input int d, input bit hold);
    bit rdy;
    int waited;
    rdy = 1'b0;
    waited = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'(d);
    while (!rdy && waited < 100) begin
      @(negedge clk);
      rdy = bus.in_ready;
      step();
      if (!rdy) begin
        waited++;
        stalls++;
      end
    end
    if (!rdy) check_eq("accept_tmo", waited, 0);
    if (!hold) begin
      bus.in_valid = 1'b0;
      bus.in_data  = 16'sh7fff;
    end
  endtask

  task automatic send_group(input int a, input int b, input int c, input int d, input bit hold);
    push_partial(a, 1'b1);
    push_partial(b, 1'b1);
    push_partial(c, 1'b1);
    push_partial(d, hold);
  endtask

  task automatic expect_out(input int v);
    exp_q.push_back(8'(v));
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, exp_q.size(), 0);
    step();
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  // scoreboard: every pop is compared against the head of the expected queue
  always @(negedge clk) begin
    if (rst_n && !clr && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) check_eq("out_extra", exp_q.size(), 1);
      else check_eq("out_data", int'(bus.out_data), int'($signed(exp_q.pop_front())));
    end
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    check_eq("rst_out_valid", bus.out_valid, 0);
    check_eq("rst_out_data", bus.out_data, 0);
    check_eq("rst_sat", sat_flag, 0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_in_ready", bus.in_ready, 1);
    step();

    // 10-3+5+7 = 19, result visible the cycle after the last accept
    expect_out(19);
    push_partial(10, 1'b1);
    push_partial(-3, 1'b1);
    push_partial(5, 1'b0);
    @(negedge clk);
    check_eq("t1_early_valid", bus.out_valid, 0);
    step();
    push_partial(7, 1'b0);
    @(negedge clk);
    check_eq("t1_latency", bus.out_valid, 1);
    check_eq("t1_sat", sat_flag, 0);
    drain("t1_drain");

    // rounding shift and ReLU
    shift = 5'd2;
    expect_out(25);
    send_group(100, 0, 0, 1, 1'b0);
    relu_en = 1'b1;
    expect_out(0);
    send_group(-5, -5, -5, -5, 1'b0);
    relu_en = 1'b0;
    expect_out(-5);
    send_group(-5, -5, -5, -5, 1'b0);
    shift = 5'd0;
    expect_out(-20);
    send_group(-5, -5, -5, -5, 1'b0);
    drain("t2_drain");
    @(negedge clk);
    check_eq("t2_sat", sat_flag, 0);
    step();

    // output clipping and sticky saturation flag
    expect_out(127);
    send_group(200, 0, 0, 0, 1'b0);
    drain("t3_pos_drain");
    @(negedge clk);
    check_eq("t3_sat_pos", sat_flag, 1);
    step();
    pulse_clr();
    @(negedge clk);
    check_eq("t3_clr_sat", sat_flag, 0);
    step();
    expect_out(-128);
    send_group(-32768, -32768, -32768, -32768, 1'b0);
    drain("t3_neg_drain");
    @(negedge clk);
    check_eq("t3_sat_neg", sat_flag, 1);
    step();
    pulse_clr();
    shift = 5'd11;
    expect_out(64);
    send_group(32767, 32767, 32767, 32767, 1'b0);
    drain("t3_shift11_drain");
    @(negedge clk);
    check_eq("t3_no_sat", sat_flag, 0);
    step();
    shift = 5'd0;

    // back-pressure: two results queue up, third group stalls until a pop
    bus.out_ready = 1'b0;
    expect_out(4);
    expect_out(8);
    expect_out(12);
    send_group(1, 1, 1, 1, 1'b0);
    send_group(2, 2, 2, 2, 1'b0);
    @(negedge clk);
    check_eq("t4_full", bus.in_ready, 0);
    check_eq("t4_head", bus.out_data, 4);
    step();
    fork
      send_group(3, 3, 3, 3, 1'b0);
      begin
        @(negedge clk);
        check_eq("t4_mid", bus.in_ready, 0);
        check_eq("t4_hold", bus.out_data, 4);
        step();
        bus.out_ready = 1'b1;
        @(negedge clk);
        check_eq("t4_rdy_pre", bus.in_ready, 0);
        step();
        @(negedge clk);
        check_eq("t4_rdy_post", bus.in_ready, 1);
        step();
      end
    join
    drain("t4_drain");

    // reset in the middle of a group discards it
    push_partial(9, 1'b1);
    push_partial(9, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("t5_rst_valid", bus.out_valid, 0);
    step();
    rst_n = 1'b1;
    expect_out(10);
    send_group(1, 2, 3, 4, 1'b0);
    drain("t5_drain");

    // clear on the final partial, then back-to-back groups with valid held high
    push_partial(5, 1'b1);
    push_partial(5, 1'b1);
    push_partial(5, 1'b1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_eq("t6_no_push", bus.out_valid, 0);
    check_eq("t6_rdy", bus.in_ready, 1);
    step();
    expect_out(4);
    send_group(1, 1, 1, 1, 1'b0);
    drain("t6_after_clr");
    stalls = 0;
    expect_out(10);
    expect_out(26);
    expect_out(-10);
    send_group(1, 2, 3, 4, 1'b1);
    send_group(5, 6, 7, 8, 1'b1);
    send_group(-1, -2, -3, -4, 1'b0);
    check_eq("t6_stalls", stalls, 0);
    drain("t6_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
